food_spawner: RTL
=================

# food_spawner

Consumer of the pseudo-random number stream in the snake game: on request, draws candidate (x, y) cells from two RNG outputs, asks the snake-body memory whether each candidate is occupied, and commits the first free cell as the new food position. After MAX_TRIES occupied random draws it falls back to a deterministic raster scan, so a free cell is always found if one exists. The block sits between the RNG instances, the snake body storage and the game-control FSM.

## Interface

Parameters:
- GRID_MIN, 1, lowest legal coordinate on both axes
- GRID_MAX, 14, highest legal coordinate on both axes
- MAX_TRIES, 8, occupied random draws before switching to raster scan (1..15)
- RESET_X, 7, food x after reset
- RESET_Y, 7, food y after reset

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- spawn_req  input  1  one-cycle request for a new food cell (food eaten)
- rnd_x  input  4  random x from RNG, sampled only in SAMPLE
- rnd_y  input  4  random y from RNG, sampled only in SAMPLE
- query_x  output  4  candidate x presented to body memory
- query_y  output  4  candidate y presented to body memory
- occupied  input  1  combinational answer for current query_x/query_y; valid in the CHECK cycle
- food_x  output  4  committed food x
- food_y  output  4  committed food y
- food_valid  output  1  food_x/food_y hold a committed free cell
- busy  output  1  high in every state except IDLE
- spawn_done  output  1  one-cycle pulse when a new cell is committed
- grid_full  output  1  one-cycle pulse when every cell was found occupied

## Operation

- States: IDLE, SAMPLE, CHECK, SCAN, DONE.
- IDLE: busy=0. spawn_req=1 -> food_valid<=0, tries<=0, scanning<=0, scanned<=0, go SAMPLE. spawn_req while busy is ignored (not queued).
- SAMPLE: cand_x<=rnd_x, cand_y<=rnd_y; any value outside [GRID_MIN, GRID_MAX] is replaced by GRID_MIN. Go CHECK.
- query_x/query_y are driven directly from cand_x/cand_y registers.
- CHECK: sample occupied.
  - occupied=0 -> DONE.
  - occupied=1, scanning=0: tries<=tries+1; if tries+1==MAX_TRIES, scanning<=1 and go SCAN, else go SAMPLE.
  - occupied=1, scanning=1: scanned<=scanned+1; if scanned+1 == (GRID_MAX-GRID_MIN+1)^2 (196 by default) -> pulse grid_full, go IDLE with food_valid=0; else go SCAN.
- SCAN: advance candidate in raster order: x<=x+1; at x==GRID_MAX, x<=GRID_MIN and y<=y+1; at y==GRID_MAX with x==GRID_MAX, wrap to (GRID_MIN, GRID_MIN). Go CHECK.
- DONE: food_x<=cand_x, food_y<=cand_y, food_valid<=1, spawn_done<=1, go IDLE.
- tries is 4 bits, scanned is 8 bits; neither wraps inside legal operation.
- Reset (any time, including mid-search): state=IDLE, food_x=RESET_X, food_y=RESET_Y, food_valid=1, busy=0, spawn_done=0, grid_full=0, cand_x=RESET_X, cand_y=RESET_Y (so query outputs = RESET_X/RESET_Y), tries=0, scanned=0, scanning=0. The interrupted search is abandoned.

## Timing

- Edge 0: spawn_req seen in IDLE -> SAMPLE; food_valid falls, busy rises.
- Edge 1: rnd sampled; query valid from this edge.
- Edge 2: occupied sampled in CHECK.
- Edge 3 (free on first draw): food regs updated, food_valid=1, spawn_done=1, busy=0.
- Edge 4: spawn_done=0.
- Each occupied random draw adds 2 cycles; each scan step adds 2 cycles.
- Worst case: 2*MAX_TRIES + 2*196 + small constant cycles.
- spawn_done and grid_full are registered, exactly one cycle wide, never both high.
- food_x/food_y change only on the DONE edge or on reset.

## Test plan

- Reset -> food=(7,7), food_valid=1, busy=0, spawn_done=0, grid_full=0.
- rnd=(3,5), occupied=0, spawn_req at edge 0 -> query=(3,5) after edge 1; food=(3,5), food_valid=1, spawn_done pulse after edge 3.
- occupied=1 for the first 7 draws, free on the 8th with rnd=(9,2) -> food=(9,2), no scan, spawn_done at edge 17.
- 8 occupied draws, last candidate (14,14), body memory reports (1,1) free -> scan wraps to (1,1), food=(1,1).
- rnd=(0,15), occupied=0 -> food=(1,1) via clamp.
- occupied held at 1 -> exactly one grid_full pulse, food_valid=0, busy=0. Separately, assert rst mid-scan -> outputs return to reset values immediately. Separately, pulse spawn_req while busy -> no effect on the ongoing search.

Source files
------------

// File: rtl/food_spawner.sv
// rtl/food_spawner.sv - picks a free food cell from RNG draws, falling back to a raster scan
module food_spawner #(
    parameter int GRID_MIN  = 1,
    parameter int GRID_MAX  = 14,
    parameter int MAX_TRIES = 8,
    parameter int RESET_X   = 7,
    parameter int RESET_Y   = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       spawn_req,
    input  logic [3:0] rnd_x,
    input  logic [3:0] rnd_y,
    output logic [3:0] query_x,
    output logic [3:0] query_y,
    input  logic       occupied,
    output logic [3:0] food_x,
    output logic [3:0] food_y,
    output logic       food_valid,
    output logic       busy,
    output logic       spawn_done,
    output logic       grid_full
);

    localparam logic [3:0] G_MIN       = 4'(GRID_MIN);
    localparam logic [3:0] G_MAX       = 4'(GRID_MAX);
    localparam logic [3:0] TRIES_LIMIT = 4'(MAX_TRIES);
    localparam logic [3:0] RST_X       = 4'(RESET_X);
    localparam logic [3:0] RST_Y       = 4'(RESET_Y);
    localparam int         GRID_SPAN   = GRID_MAX - GRID_MIN + 1;
    localparam logic [7:0] GRID_CELLS  = 8'(GRID_SPAN * GRID_SPAN);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SAMPLE = 3'd1,
        CHECK  = 3'd2,
        SCAN   = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t     state, state_n;
    logic [3:0] cand_x, cand_x_n;
    logic [3:0] cand_y, cand_y_n;
    logic [3:0] food_x_r, food_x_n;
    logic [3:0] food_y_r, food_y_n;
    logic       food_valid_r, food_valid_n;
    logic       spawn_done_r, spawn_done_n;
    logic       grid_full_r, grid_full_n;
    logic [3:0] tries, tries_n;
    logic [7:0] scanned, scanned_n;
    logic       scanning, scanning_n;

    // Out-of-grid RNG values are pulled onto the first legal coordinate.
    function automatic logic [3:0] clamp_coord(input logic [3:0] v);
        if ((v < G_MIN) || (v > G_MAX)) begin
            return G_MIN;
        end
        return v;
    endfunction

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Datapath registers: candidate, committed food, counters and pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cand_x       <= RST_X;
            cand_y       <= RST_Y;
            food_x_r     <= RST_X;
            food_y_r     <= RST_Y;
            food_valid_r <= 1'b1;
            spawn_done_r <= 1'b0;
            grid_full_r  <= 1'b0;
            tries        <= 4'd0;
            scanned      <= 8'd0;
            scanning     <= 1'b0;
        end else begin
            cand_x       <= cand_x_n;
            cand_y       <= cand_y_n;
            food_x_r     <= food_x_n;
            food_y_r     <= food_y_n;
            food_valid_r <= food_valid_n;
            spawn_done_r <= spawn_done_n;
            grid_full_r  <= grid_full_n;
            tries        <= tries_n;
            scanned      <= scanned_n;
            scanning     <= scanning_n;
        end
    end

    // Next-state and next-datapath logic; pulses default low so they last one cycle.
    always_comb begin
        state_n      = state;
        cand_x_n     = cand_x;
        cand_y_n     = cand_y;
        food_x_n     = food_x_r;
        food_y_n     = food_y_r;
        food_valid_n = food_valid_r;
        spawn_done_n = 1'b0;
        grid_full_n  = 1'b0;
        tries_n      = tries;
        scanned_n    = scanned;
        scanning_n   = scanning;

        case (state)
            IDLE: begin
                if (spawn_req) begin
                    food_valid_n = 1'b0;
                    tries_n      = 4'd0;
                    scanning_n   = 1'b0;
                    scanned_n    = 8'd0;
                    state_n      = SAMPLE;
                end
            end

            SAMPLE: begin
                cand_x_n = clamp_coord(rnd_x);
                cand_y_n = clamp_coord(rnd_y);
                state_n  = CHECK;
            end

            CHECK: begin
                if (!occupied) begin
                    state_n = DONE;
                end else if (!scanning) begin
                    tries_n = tries + 4'd1;
                    if (tries_n == TRIES_LIMIT) begin
                        scanning_n = 1'b1;
                        state_n    = SCAN;
                    end else begin
                        state_n = SAMPLE;
                    end
                end else begin
                    scanned_n = scanned + 8'd1;
                    if (scanned_n == GRID_CELLS) begin
                        // Every cell has been visited once by the scan: no room left.
                        grid_full_n = 1'b1;
                        state_n     = IDLE;
                    end else begin
                        state_n = SCAN;
                    end
                end
            end

            SCAN: begin
                if (cand_x == G_MAX) begin
                    cand_x_n = G_MIN;
                    cand_y_n = (cand_y == G_MAX) ? G_MIN : cand_y + 4'd1;
                end else begin
                    cand_x_n = cand_x + 4'd1;
                end
                state_n = CHECK;
            end

            DONE: begin
                food_x_n     = cand_x;
                food_y_n     = cand_y;
                food_valid_n = 1'b1;
                spawn_done_n = 1'b1;
                state_n      = IDLE;
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign query_x    = cand_x;
    assign query_y    = cand_y;
    assign food_x     = food_x_r;
    assign food_y     = food_y_r;
    assign food_valid = food_valid_r;
    assign spawn_done = spawn_done_r;
    assign grid_full  = grid_full_r;
    assign busy       = (state != IDLE);

endmodule
